md_unit: RTL and testbench

Multi-cycle multiply/divide unit for the P6 pipelined MIPS core. It sits in the E stage beside the ALU and owns the HI/LO registers. It sequences mult/multu/div/divu through a fixed-latency busy period and drives the `Busy` signal, which the hazard unit combines with `StartE` to stall multiply/divide-class instructions in D. It also performs mthi/mtlo writes and exposes HI/LO for mfhi/mflo.

---
 rtl/md_unit_if.sv | 15 +
 rtl/md_unit.sv | 163 ++++++++++++++++
 tb/tb_md_unit.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/md_unit_if.sv
// rtl/md_unit_if.sv - issue/result bundle between the E stage and the multiply/divide unit
interface md_unit_if;
  logic        Start;
  logic [2:0]  MDOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (output Start, output MDOp, output A, output B,
                  input Busy, input HI, input LO);
  modport slave  (input Start, input MDOp, input A, input B,
                  output Busy, output HI, output LO);
endinterface

// File: rtl/md_unit.sv
// rtl/md_unit.sv - fixed-latency multiply/divide unit owning HI/LO (optional madd/maddu via MD_MADD_EN)
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic     clk,
  input  logic     reset,
  md_unit_if.slave bus
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic        load, commit;
  logic [31:0] hi_q, lo_q, phi, plo;
  logic        pwe;

  // Operand decode and result of the op presented this cycle
  logic        run_op, res_we;
  logic [3:0]  run_load;
  logic [31:0] res_hi, res_lo;
  logic        mthi_wr, mtlo_wr;

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, b_sdiv, b_udiv;
  logic [31:0] uq, ur, sq, sr, dq, dr;

  assign prod_s = $signed({{32{bus.A[31]}}, bus.A}) * $signed({{32{bus.B[31]}}, bus.B});
  assign prod_u = {32'd0, bus.A} * {32'd0, bus.B};

  // Signed divide runs on magnitudes so INT_MIN / -1 simply wraps to INT_MIN.
  // A zero divisor is swapped for 1 to keep the divider defined; its result is never committed.
  assign a_neg  = bus.A[31];
  assign b_neg  = bus.B[31];
  assign a_mag  = a_neg ? (32'd0 - bus.A) : bus.A;
  assign b_mag  = b_neg ? (32'd0 - bus.B) : bus.B;
  assign b_sdiv = (bus.B == 32'd0) ? 32'd1 : b_mag;
  assign b_udiv = (bus.B == 32'd0) ? 32'd1 : bus.B;
  assign uq     = a_mag / b_sdiv;
  assign ur     = a_mag % b_sdiv;
  assign sq     = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
  assign sr     = a_neg ? (32'd0 - ur) : ur;
  assign dq     = bus.A / b_udiv;
  assign dr     = bus.A % b_udiv;

  assign mthi_wr = (state == IDLE) && bus.Start && (bus.MDOp == 3'b100);
  assign mtlo_wr = (state == IDLE) && bus.Start && (bus.MDOp == 3'b101);

  // Select the pending result and busy length for the issued op
  always_comb begin
    run_op   = 1'b0;
    run_load = MULT_LOAD;
    res_we   = 1'b1;
    res_hi   = 32'd0;
    res_lo   = 32'd0;
    case (bus.MDOp)
      3'b000: begin
        run_op = 1'b1;
        {res_hi, res_lo} = prod_s;
      end
      3'b001: begin
        run_op = 1'b1;
        {res_hi, res_lo} = prod_u;
      end
      3'b010: begin
        run_op   = 1'b1;
        run_load = DIV_LOAD;
        res_lo   = sq;
        res_hi   = sr;
        res_we   = (bus.B != 32'd0);
      end
      3'b011: begin
        run_op   = 1'b1;
        run_load = DIV_LOAD;
        res_lo   = dq;
        res_hi   = dr;
        res_we   = (bus.B != 32'd0);
      end
`ifdef MD_MADD_EN
      3'b110: begin
        run_op = 1'b1;
        {res_hi, res_lo} = {hi_q, lo_q} + prod_s;
      end
      3'b111: begin
        run_op = 1'b1;
        {res_hi, res_lo} = {hi_q, lo_q} + prod_u;
      end
`endif
      default: ;
    endcase
  end

  // FSM state and countdown register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next state: accept a multi-cycle op in IDLE, count down in RUN, commit at zero
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    load    = 1'b0;
    commit  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.Start && run_op) begin
          state_n = RUN;
          cnt_n   = run_load;
          load    = 1'b1;
        end
      end
      RUN: begin
        if (cnt == 4'd0) begin
          state_n = IDLE;
          commit  = 1'b1;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Pending capture at issue, architectural HI/LO update at commit or mthi/mtlo
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q <= 32'd0;
      lo_q <= 32'd0;
      phi  <= 32'd0;
      plo  <= 32'd0;
      pwe  <= 1'b0;
    end else begin
      if (load) begin
        phi <= res_hi;
        plo <= res_lo;
        pwe <= res_we;
      end
      if (commit && pwe) begin
        hi_q <= phi;
        lo_q <= plo;
      end
      if (mthi_wr) hi_q <= bus.A;
      if (mtlo_wr) lo_q <= bus.A;
    end
  end

  assign bus.Busy = (state == RUN);
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - randomized self-checking bench for md_unit against an arithmetic reference model
module tb_md_unit;
  localparam int MC = 5;
  localparam int DC = 10;

  logic clk;
  logic reset;
  md_unit_if bus();

  md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] ref_hi = 32'd0;
  logic [31:0] ref_lo = 32'd0;

  // Architectural effect of one op on the reference HI/LO; returns the expected Busy length
  task automatic model_apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                             output int n);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    n  = 0;
    case (op)
      3'd0: begin p = 64'(sa * sb); {ref_hi, ref_lo} = p; n = MC; end
      3'd1: begin p = {32'd0, a} * {32'd0, b}; {ref_hi, ref_lo} = p; n = MC; end
      3'd2: begin
        n = DC;
        if (b != 0) begin
          q = sa / sb;
          r = sa % sb;
          ref_lo = q[31:0];
          ref_hi = r[31:0];
        end
      end
      3'd3: begin
        n = DC;
        if (b != 0) begin
          ref_lo = a / b;
          ref_hi = a % b;
        end
      end
      3'd4: ref_hi = a;
      3'd5: ref_lo = a;
`ifdef MD_MADD_EN
      3'd6: begin p = {ref_hi, ref_lo} + 64'(sa * sb); {ref_hi, ref_lo} = p; n = MC; end
      3'd7: begin p = {ref_hi, ref_lo} + {32'd0, a} * {32'd0, b}; {ref_hi, ref_lo} = p; n = MC; end
`endif
      default: ;
    endcase
  endtask

  // Issue one op at the current negedge, optionally pulse an mtlo at busy cycle 'inject'
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string name, input int inject);
    logic [31:0] old_hi, old_lo;
    int exp_n, n;
    old_hi = ref_hi;
    old_lo = ref_lo;
    model_apply(op, a, b, exp_n);
    bus.Start = 1'b1; bus.MDOp = op; bus.A = a; bus.B = b;
    @(negedge clk);
    bus.Start = 1'b0; bus.A = $urandom; bus.B = $urandom;
    n = 0;
    while (bus.Busy === 1'b1 && n < 40) begin
      checks++;
      if (bus.HI !== old_hi || bus.LO !== old_lo) begin
        errors++;
        $display("FAIL %s hold cyc%0d: HI=%h LO=%h expected HI=%h LO=%h", name, n, bus.HI, bus.LO, old_hi, old_lo);
      end
      if (n == inject) begin
        bus.Start = 1'b1; bus.MDOp = 3'b101; bus.A = 32'h99;
      end else begin
        bus.Start = 1'b0;
      end
      n++;
      @(negedge clk);
    end
    bus.Start = 1'b0;
    checks++;
    if (n !== exp_n) begin
      errors++;
      $display("FAIL %s busy_cycles: got %0d expected %0d", name, n, exp_n);
    end
    checks++;
    if (bus.HI !== ref_hi || bus.LO !== ref_lo) begin
      errors++;
      $display("FAIL %s result: HI=%h LO=%h expected HI=%h LO=%h", name, bus.HI, bus.LO, ref_hi, ref_lo);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (bus.Busy !== 1'b0 || bus.HI !== 32'd0 || bus.LO !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: Busy=%b HI=%h LO=%h expected 0 0 0", bus.Busy, bus.HI, bus.LO);
    end
  endtask

  task automatic test_mult();
    run_op(3'd0, 32'hFFFFFFFF, 32'd2, "mult_neg1x2", -1);
    checks++;
    if (ref_hi !== 32'hFFFFFFFF || ref_lo !== 32'hFFFFFFFE) begin
      errors++;
      $display("FAIL mult_model: HI=%h LO=%h expected ffffffff fffffffe", ref_hi, ref_lo);
    end
    run_op(3'd1, 32'hFFFFFFFF, 32'd2, "multu_ffx2", -1);
    checks++;
    if (bus.HI !== 32'd1 || bus.LO !== 32'hFFFFFFFE) begin
      errors++;
      $display("FAIL multu_const: HI=%h LO=%h expected 00000001 fffffffe", bus.HI, bus.LO);
    end
  endtask

  task automatic test_div();
    run_op(3'd2, 32'hFFFFFFF9, 32'd2, "div_m7by2", -1);
    checks++;
    if (bus.LO !== 32'hFFFFFFFD || bus.HI !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL div_const: HI=%h LO=%h expected ffffffff fffffffd", bus.HI, bus.LO);
    end
    run_op(3'd3, 32'd7, 32'd2, "divu_7by2", -1);
    checks++;
    if (bus.LO !== 32'd3 || bus.HI !== 32'd1) begin
      errors++;
      $display("FAIL divu_const: HI=%h LO=%h expected 1 3", bus.HI, bus.LO);
    end
    run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, "div_overflow", -1);
    checks++;
    if (bus.LO !== 32'h80000000 || bus.HI !== 32'd0) begin
      errors++;
      $display("FAIL div_overflow_const: HI=%h LO=%h expected 0 80000000", bus.HI, bus.LO);
    end
  endtask

  task automatic test_divzero();
    run_op(3'd4, 32'h11, 32'd0, "mthi", -1);
    run_op(3'd5, 32'h22, 32'd0, "mtlo", -1);
    run_op(3'd2, 32'd5, 32'd0, "div_by_zero", -1);
    run_op(3'd3, 32'd9, 32'd0, "divu_by_zero", -1);
    checks++;
    if (bus.HI !== 32'h11 || bus.LO !== 32'h22) begin
      errors++;
      $display("FAIL divzero_const: HI=%h LO=%h expected 11 22", bus.HI, bus.LO);
    end
  endtask

  task automatic test_ignored_start();
    run_op(3'd0, 32'd2, 32'd3, "ignored_start", 2);
    checks++;
    if (bus.HI !== 32'd0 || bus.LO !== 32'd6) begin
      errors++;
      $display("FAIL ignored_start_const: HI=%h LO=%h expected 0 6", bus.HI, bus.LO);
    end
  endtask

  task automatic test_madd();
    run_op(3'd4, 32'd0, 32'd0, "madd_mthi", -1);
    run_op(3'd5, 32'hFFFFFFFF, 32'd0, "madd_mtlo", -1);
    run_op(3'd7, 32'd1, 32'd1, "maddu_1x1", -1);
    run_op(3'd6, 32'hFFFFFFFF, 32'd3, "madd_neg", -1);
  endtask

  task automatic test_reset_midrun();
    int bad;
    run_op(3'd4, 32'h55, 32'd0, "pre_reset_mthi", -1);
    bus.Start = 1'b1; bus.MDOp = 3'd0; bus.A = 32'd3; bus.B = 32'd4;
    @(negedge clk);
    bus.Start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (bus.Busy !== 1'b0 || bus.HI !== 32'd0 || bus.LO !== 32'd0) begin
      errors++;
      $display("FAIL reset_midrun: Busy=%b HI=%h LO=%h expected 0 0 0", bus.Busy, bus.HI, bus.LO);
    end
    @(negedge clk);
    reset = 1'b0;
    ref_hi = 32'd0;
    ref_lo = 32'd0;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.Busy !== 1'b0 || bus.HI !== 32'd0 || bus.LO !== 32'd0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_no_commit: %0d bad cycles expected 0", bad);
    end
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 5) == 0) b = 32'd0;
      if ($urandom_range(0, 7) == 0) b = 32'($urandom_range(1, 9));
      if ($urandom_range(0, 9) == 0) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
      run_op(op, a, b, "random", -1);
    end
  endtask

  task automatic test_back_to_back();
    run_op(3'd0, 32'd1000, 32'hFFFFFF00, "b2b_mult", -1);
    run_op(3'd2, 32'd100, 32'hFFFFFFF9, "b2b_div", -1);
    run_op(3'd5, 32'hABCD, 32'd0, "b2b_mtlo", -1);
    run_op(3'd1, 32'hDEADBEEF, 32'hCAFEF00D, "b2b_multu", -1);
  endtask

  initial begin
    reset = 1'b1;
    bus.Start = 1'b0; bus.MDOp = 3'd0; bus.A = 32'd0; bus.B = 32'd0;
    @(negedge clk);
    @(negedge clk);
    test_reset();
    reset = 1'b0;
    @(negedge clk);
    test_mult();
    test_div();
    test_divzero();
    test_ignored_start();
    test_madd();
    test_back_to_back();
    test_random();
    test_reset_midrun();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
